// File: rtl/smoldvi_deserialiser.sv
// TMDS lane deserialiser: rebuilds 10-bit symbols from a 2-bit DDR stream and
// bit-slips until TMDS control symbols repeat at a stable offset.
module smoldvi_deserialiser #(
  parameter int unsigned CTRL_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_x5,
  input  logic       rst_x5,
  input  logic [1:0] din,
  output logic [9:0] sym,
  output logic       sym_valid,
  output logic       ctrl_det,
  output logic       locked,
  output logic       slip
);

  localparam int unsigned SYM_W   = 10;
  localparam int unsigned HIST_W  = 20;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned OFF_W   = 4;
  localparam int unsigned RUN_W   = $clog2(CTRL_RUN + 1);
  localparam int unsigned GAP_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [SYM_W-1:0] CTRL_0 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_1 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_2 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_3 = 10'b1010101011;

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } state_t;

  logic [HIST_W-1:0]  hist;
  logic [HIST_W-1:0]  hist_nxt_c;
  logic [PHASE_W-1:0] phase;
  logic [OFF_W-1:0]   offset, offset_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [GAP_W-1:0]   gap, gap_n, gap_inc_c;
  state_t             state, state_n;
  logic               capture_c;
  logic [SYM_W-1:0]   win_c;
  logic               is_ctrl_c;
  logic               slip_c;

  // Window extraction and control-symbol detection on the post-shift history
  always_comb begin
    hist_nxt_c = {din, hist[HIST_W-1:2]};
    capture_c  = (phase == PHASE_W'(4));
    win_c      = SYM_W'(hist_nxt_c >> offset);
    is_ctrl_c  = (win_c == CTRL_0) || (win_c == CTRL_1) ||
                 (win_c == CTRL_2) || (win_c == CTRL_3);
    gap_inc_c  = (gap == GAP_W'(GAP_MAX)) ? gap : gap + GAP_W'(1);
  end

  // Alignment FSM next state, evaluated once per symbol on capture cycles
  always_comb begin
    state_n  = state;
    run_n    = run;
    gap_n    = gap;
    offset_n = offset;
    slip_c   = 1'b0;
    if (capture_c) begin
      case (state)
        ST_HUNT: begin
          if (is_ctrl_c) begin
            run_n = run + RUN_W'(1);
            gap_n = '0;
          end else begin
            run_n = '0;
            gap_n = gap_inc_c;
          end
          if (run_n == RUN_W'(CTRL_RUN)) begin
            state_n = ST_LOCKED;
            run_n   = '0;
            gap_n   = '0;
          end else if (gap_n == GAP_W'(SEARCH_TIMEOUT)) begin
            offset_n = (offset == OFF_W'(9)) ? '0 : offset + OFF_W'(1);
            slip_c   = 1'b1;
            run_n    = '0;
            gap_n    = '0;
          end
        end
        ST_LOCKED: begin
          gap_n = is_ctrl_c ? '0 : gap_inc_c;
          if (gap_n == GAP_W'(LOSS_TIMEOUT)) begin
            state_n = ST_HUNT;
            run_n   = '0;
            gap_n   = '0;
          end
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  // Alignment state registers
  always_ff @(posedge clk_x5 or posedge rst_x5) begin
    if (rst_x5) begin
      state  <= ST_HUNT;
      run    <= '0;
      gap    <= '0;
      offset <= '0;
    end else begin
      state  <= state_n;
      run    <= run_n;
      gap    <= gap_n;
      offset <= offset_n;
    end
  end

  // Bit history, fixed symbol cadence and registered outputs
  always_ff @(posedge clk_x5 or posedge rst_x5) begin
    if (rst_x5) begin
      hist      <= '0;
      phase     <= '0;
      sym       <= '0;
      sym_valid <= 1'b0;
      ctrl_det  <= 1'b0;
      locked    <= 1'b0;
      slip      <= 1'b0;
    end else begin
      hist      <= hist_nxt_c;
      phase     <= capture_c ? '0 : phase + PHASE_W'(1);
      sym_valid <= capture_c;
      ctrl_det  <= capture_c && is_ctrl_c;
      locked    <= (state_n == ST_LOCKED);
      slip      <= slip_c;
      if (capture_c) begin
        sym <= win_c;
      end
    end
  end

endmodule

// File: tb/tb_smoldvi_deserialiser.sv
// Bench for smoldvi_deserialiser: directed alignment scenarios plus random
// traffic, every cycle compared against a bit-stream reference model.
module tb_smoldvi_deserialiser;

  localparam int unsigned CTRL_RUN  = 8;
  localparam int unsigned SEARCH_TO = 4;
  localparam int unsigned LOSS_TO   = 16;

  localparam logic [9:0] CTRL0 = 10'b1101010100;
  localparam logic [9:0] CTRL1 = 10'b0010101011;
  localparam logic [9:0] CTRL2 = 10'b0101010100;
  localparam logic [9:0] CTRL3 = 10'b1010101011;
  localparam logic [9:0] DATA  = 10'b0111110000;

  logic       clk_x5 = 1'b0;
  logic       rst_x5 = 1'b0;
  logic [1:0] din    = 2'b11;
  logic [9:0] sym;
  logic       sym_valid;
  logic       ctrl_det;
  logic       locked;
  logic       slip;

  always #5 clk_x5 = ~clk_x5;

  smoldvi_deserialiser #(
    .CTRL_RUN      (CTRL_RUN),
    .SEARCH_TIMEOUT(SEARCH_TO),
    .LOSS_TIMEOUT  (LOSS_TO)
  ) dut (
    .clk_x5   (clk_x5),
    .rst_x5   (rst_x5),
    .din      (din),
    .sym      (sym),
    .sym_valid(sym_valid),
    .ctrl_det (ctrl_det),
    .locked   (locked),
    .slip     (slip)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: every received bit in order, preceded by 10 zero bits
  // standing in for the cleared history. Symbol k at offset o is bits
  // 10k+o .. 10k+o+9 of this stream.
  bit         pre_q[$];
  bit         tx_q[$];
  int         m_edge;
  int         m_off;
  int         m_run;
  int         m_gap;
  bit         m_locked;
  logic [9:0] e_sym;
  bit         e_valid;
  bit         e_ctrl;
  bit         e_slip;
  int         dut_slips;
  int         dut_valids;
  logic [9:0] ctrl_tab [4];

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_ctrl_word(input logic [9:0] w);
    return (w == CTRL0) || (w == CTRL1) || (w == CTRL2) || (w == CTRL3);
  endfunction

  task automatic model_reset();
    pre_q.delete();
    tx_q.delete();
    repeat (10) pre_q.push_back(1'b0);
    m_edge   = 0;
    m_off    = 0;
    m_run    = 0;
    m_gap    = 0;
    m_locked = 1'b0;
    e_sym    = '0;
    e_valid  = 1'b0;
    e_ctrl   = 1'b0;
    e_slip   = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] d);
    int         base;
    logic [9:0] w;
    bit         c;
    pre_q.push_back(d[0]);
    pre_q.push_back(d[1]);
    m_edge++;
    e_valid = 1'b0;
    e_ctrl  = 1'b0;
    e_slip  = 1'b0;
    if (m_edge % 5 == 0) begin
      base = 10 * (m_edge / 5 - 1) + m_off;
      for (int i = 0; i < 10; i++) w[i] = pre_q[base + i];
      c       = is_ctrl_word(w);
      e_sym   = w;
      e_valid = 1'b1;
      e_ctrl  = c;
      if (!m_locked) begin
        if (c) begin m_run++; m_gap = 0; end
        else begin m_run = 0; m_gap++; end
        if (m_run == CTRL_RUN) begin
          m_locked = 1'b1; m_run = 0; m_gap = 0;
        end else if (m_gap == SEARCH_TO) begin
          m_off  = (m_off + 1) % 10;
          e_slip = 1'b1;
          m_run  = 0; m_gap = 0;
        end
      end else begin
        if (c) m_gap = 0;
        else m_gap++;
        if (m_gap == LOSS_TO) begin
          m_locked = 1'b0; m_run = 0; m_gap = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("sym",       sym,            e_sym);
    chk("sym_valid", 10'(sym_valid), 10'(e_valid));
    chk("ctrl_det",  10'(ctrl_det),  10'(e_ctrl));
    chk("locked",    10'(locked),    10'(m_locked));
    chk("slip",      10'(slip),      10'(e_slip));
    if (slip === 1'b1) dut_slips++;
    if (sym_valid === 1'b1) dut_valids++;
  endtask

  task automatic cycle(input logic [1:0] d);
    din = d;
    @(posedge clk_x5);
    #1;
    model_step(d);
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst_x5 = 1'b1;
    din    = 2'b11;
    #1;
    model_reset();
    check_all();
    repeat (n) begin
      @(posedge clk_x5);
      #1;
      check_all();
    end
    rst_x5     = 1'b0;
    dut_slips  = 0;
    dut_valids = 0;
  endtask

  task automatic push_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) tx_q.push_back(w[i]);
  endtask

  task automatic drain();
    logic [1:0] d;
    while (tx_q.size() >= 2) begin
      d[0] = tx_q.pop_front();
      d[1] = tx_q.pop_front();
      cycle(d);
    end
  endtask

  initial begin
    int len;
    int kind;
    logic [9:0] w;
    ctrl_tab[0] = CTRL0;
    ctrl_tab[1] = CTRL1;
    ctrl_tab[2] = CTRL2;
    ctrl_tab[3] = CTRL3;
    dut_slips  = 0;
    dut_valids = 0;

    // Reset held 3 cycles with din=11
    do_reset(3);

    // Aligned control stream at offset 0
    repeat (20) push_word(CTRL0);
    drain();
    chk("aligned_slips",  10'(dut_slips),  10'd0);
    chk("aligned_locked", 10'(locked),     10'd1);
    chk("aligned_valids", 10'(dut_valids), 10'd20);

    // Misaligned by 3 bits: three slips then lock
    do_reset(2);
    repeat (3) tx_q.push_back(1'b0);
    repeat (30) push_word(CTRL1);
    drain();
    chk("misalign_slips",  10'(dut_slips), 10'd3);
    chk("misalign_locked", 10'(locked),    10'd1);
    chk("misalign_sym",    sym,            CTRL1);

    // Offset wrap: first slip to 1, then 9 more slips through 9 -> 0
    do_reset(2);
    repeat (40) tx_q.push_back(1'b0);
    repeat (60) push_word(CTRL3);
    drain();
    chk("wrap_slips",  10'(dut_slips),  10'd10);
    chk("wrap_locked", 10'(locked),     10'd1);
    chk("wrap_valids", 10'(dut_valids), 10'(m_edge / 5));
    chk("wrap_sym",    sym,             CTRL3);

    // Loss of lock: 15 data, one control, then 16 data
    do_reset(2);
    repeat (10) push_word(CTRL0);
    repeat (15) push_word(DATA);
    push_word(CTRL0);
    repeat (16) push_word(DATA);
    drain();
    chk("loss_held_15", 10'(locked), 10'd1);
    push_word(DATA);
    drain();
    chk("loss_drop_16", 10'(locked), 10'd0);

    // Reset at phase 2 while locked, then relock after 8 control symbols
    do_reset(2);
    repeat (10) push_word(CTRL2);
    drain();
    chk("midrst_pre_locked", 10'(locked), 10'd1);
    while (m_edge % 5 != 2) cycle(2'b10);
    #2;
    do_reset(1);
    chk("midrst_locked", 10'(locked), 10'd0);
    repeat (8) push_word(CTRL2);
    drain();
    chk("relock_7", 10'(locked), 10'd0);
    push_word(CTRL2);
    drain();
    chk("relock_8",    10'(locked),    10'd1);
    chk("relock_slip", 10'(dut_slips), 10'd0);

    // Random bursts of control and data words with occasional bit slips
    do_reset(2);
    repeat ($urandom_range(0, 9)) tx_q.push_back(1'($urandom));
    for (int b = 0; b < 40; b++) begin
      len  = $urandom_range(1, 12);
      kind = $urandom_range(0, 2);
      for (int j = 0; j < len; j++) begin
        w = (kind != 0) ? ctrl_tab[$urandom_range(0, 3)] : 10'($urandom);
        push_word(w);
        if ($urandom_range(0, 29) == 0) tx_q.push_back(1'($urandom));
      end
      drain();
      if (b == 20) begin
        #2;
        do_reset(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
